// File: rtl/multi_cycle_controller_if.sv
// Control bus between the multi-cycle controller and its datapath.
// The datapath side drives instruction fields and memory status.
interface multi_cycle_controller_if;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic       MemReady;
    logic       IRWrite;
    logic       NextPC;
    logic       RegW;
    logic       MemW;
    logic       Branch;
    logic       AdrSrc;
    logic       ALUSrcA;
    logic       ALUOp;
    logic [1:0] ALUSrcB;
    logic [1:0] ResultSrc;
    logic [1:0] ImmSrc;
    logic [1:0] RegSrc;
    logic       Retire;
    logic       Illegal;
    logic [3:0] State;

    modport master (
        output Op, Funct, MemReady,
        input  IRWrite, NextPC, RegW, MemW, Branch,
        input  AdrSrc, ALUSrcA, ALUOp,
        input  ALUSrcB, ResultSrc, ImmSrc, RegSrc,
        input  Retire, Illegal, State
    );

    modport slave (
        input  Op, Funct, MemReady,
        output IRWrite, NextPC, RegW, MemW, Branch,
        output AdrSrc, ALUSrcA, ALUOp,
        output ALUSrcB, ResultSrc, ImmSrc, RegSrc,
        output Retire, Illegal, State
    );
endinterface

// File: rtl/multi_cycle_controller.sv
// Multi-cycle processor control FSM sharing one memory for
// instruction fetch and data access; stalls on MemReady.
module multi_cycle_controller (
    input  logic                     clk,
    input  logic                     reset_n,
    multi_cycle_controller_if.slave  bus
);
    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXECR  = 4'd6,
        EXECI  = 4'd7,
        ALUWB  = 4'd8,
        BRANCH = 4'd9
    } state_e;

    state_e state_q, state_d;

    logic i_bit, s_bit;
    logic unused_funct;
    logic irw, npc, regw, memw, br, ret, ill;
    logic adr, srca, aluop;
    logic [1:0] srcb, res;

    assign i_bit        = bus.Funct[5];
    assign s_bit        = bus.Funct[0];
    assign unused_funct = ^bus.Funct[4:1];

    // Next-state selection; unused codes fall back to FETCH.
    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH:  state_d = bus.MemReady ? DECODE : FETCH;
            DECODE: begin
                case (bus.Op)
                    2'b00:   state_d = i_bit ? EXECI : EXECR;
                    2'b01:   state_d = MEMADR;
                    2'b10:   state_d = BRANCH;
                    default: state_d = FETCH;
                endcase
            end
            MEMADR: state_d = s_bit ? MEMRD : MEMWR;
            MEMRD:  state_d = bus.MemReady ? MEMWB : MEMRD;
            MEMWR:  state_d = bus.MemReady ? FETCH : MEMWR;
            EXECR:  state_d = ALUWB;
            EXECI:  state_d = ALUWB;
            default: state_d = FETCH;
        endcase
    end

    // State register; reset drops any instruction in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= FETCH;
        else          state_q <= state_d;
    end

    // Per-state strobes and mux selects; everything defaults to 0.
    always_comb begin
        irw   = 1'b0;
        npc   = 1'b0;
        regw  = 1'b0;
        memw  = 1'b0;
        br    = 1'b0;
        ret   = 1'b0;
        ill   = 1'b0;
        adr   = 1'b0;
        srca  = 1'b0;
        aluop = 1'b0;
        srcb  = 2'b00;
        res   = 2'b00;
        case (state_q)
            FETCH: begin
                srca = 1'b1;
                srcb = 2'b10;
                res  = 2'b10;
                irw  = bus.MemReady;
                npc  = bus.MemReady;
            end
            DECODE: begin
                srca = 1'b1;
                srcb = 2'b10;
                res  = 2'b10;
                ill  = (bus.Op == 2'b11);
            end
            MEMADR: srcb = 2'b01;
            MEMRD:  adr = 1'b1;
            MEMWB: begin
                res  = 2'b01;
                regw = 1'b1;
                ret  = 1'b1;
            end
            MEMWR: begin
                adr  = 1'b1;
                memw = 1'b1;
                ret  = bus.MemReady;
            end
            EXECR:  aluop = 1'b1;
            EXECI: begin
                srcb  = 2'b01;
                aluop = 1'b1;
            end
            ALUWB: begin
                regw = 1'b1;
                ret  = 1'b1;
            end
            BRANCH: begin
                srcb = 2'b01;
                res  = 2'b10;
                br   = 1'b1;
                ret  = 1'b1;
            end
            default: ;
        endcase
    end

    // Strobes are gated so reset silences them without a clock edge.
    assign bus.IRWrite   = irw  & reset_n;
    assign bus.NextPC    = npc  & reset_n;
    assign bus.RegW      = regw & reset_n;
    assign bus.MemW      = memw & reset_n;
    assign bus.Branch    = br   & reset_n;
    assign bus.Retire    = ret  & reset_n;
    assign bus.Illegal   = ill  & reset_n;
    assign bus.AdrSrc    = adr;
    assign bus.ALUSrcA   = srca;
    assign bus.ALUOp     = aluop;
    assign bus.ALUSrcB   = srcb;
    assign bus.ResultSrc = res;
    assign bus.ImmSrc    = bus.Op;
    assign bus.RegSrc    = {(bus.Op == 2'b01) & ~s_bit, bus.Op == 2'b10};
    assign bus.State     = state_q;
endmodule

// File: tb/tb_multi_cycle_controller.sv
// Bench for the multi-cycle controller: instruction-level traces
// with random stalls compared cycle by cycle against a reference.
module tb_multi_cycle_controller;
    logic clk = 1'b0;
    logic reset_n;

    multi_cycle_controller_if bus ();

    multi_cycle_controller dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] st;
        logic       irw, npc, regw, memw, br;
        logic       adr, srca, aluop;
        logic [1:0] srcb, res, imm, regsrc;
        logic       ret, ill;
    } obs_t;

    obs_t exp_q[$];
    obs_t obs_q[$];
    bit   mr_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Output table of each state as listed in the control description.
    function automatic obs_t ref_out(int st, bit mr, logic [1:0] op, bit s);
        obs_t o;
        o        = '0;
        o.st     = st[3:0];
        o.imm    = op;
        o.regsrc = {(op == 2'b01) && !s, op == 2'b10};
        case (st)
            0: begin o.srca = 1; o.srcb = 2; o.res = 2; o.irw = mr; o.npc = mr; end
            1: begin o.srca = 1; o.srcb = 2; o.res = 2; o.ill = (op == 2'b11); end
            2: begin o.srcb = 1; end
            3: begin o.adr = 1; end
            4: begin o.res = 1; o.regw = 1; o.ret = 1; end
            5: begin o.adr = 1; o.memw = 1; o.ret = mr; end
            6: begin o.aluop = 1; end
            7: begin o.srcb = 1; o.aluop = 1; end
            8: begin o.regw = 1; o.ret = 1; end
            9: begin o.srcb = 1; o.res = 2; o.br = 1; o.ret = 1; end
            default: ;
        endcase
        return o;
    endfunction

    function automatic void add(int st, bit mr, logic [1:0] op, bit s);
        exp_q.push_back(ref_out(st, mr, op, s));
        mr_q.push_back(mr);
    endfunction

    // Expected per-cycle trace of one whole instruction.
    function automatic void build(logic [1:0] op, logic [5:0] f,
                                  int fstall, int mstall);
        bit s, i;
        s = f[0];
        i = f[5];
        exp_q.delete();
        mr_q.delete();
        repeat (fstall) add(0, 0, op, s);
        add(0, 1, op, s);
        add(1, 1'($urandom_range(0, 1)), op, s);
        case (op)
            2'b00: begin
                add(i ? 7 : 6, 1'($urandom_range(0, 1)), op, s);
                add(8, 1'($urandom_range(0, 1)), op, s);
            end
            2'b01: begin
                add(2, 1'($urandom_range(0, 1)), op, s);
                if (s) begin
                    repeat (mstall) add(3, 0, op, s);
                    add(3, 1, op, s);
                    add(4, 1'($urandom_range(0, 1)), op, s);
                end else begin
                    repeat (mstall) add(5, 0, op, s);
                    add(5, 1, op, s);
                end
            end
            2'b10: add(9, 1'($urandom_range(0, 1)), op, s);
            default: ;
        endcase
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.st     = bus.State;
        o.irw    = bus.IRWrite;
        o.npc    = bus.NextPC;
        o.regw   = bus.RegW;
        o.memw   = bus.MemW;
        o.br     = bus.Branch;
        o.adr    = bus.AdrSrc;
        o.srca   = bus.ALUSrcA;
        o.aluop  = bus.ALUOp;
        o.srcb   = bus.ALUSrcB;
        o.res    = bus.ResultSrc;
        o.imm    = bus.ImmSrc;
        o.regsrc = bus.RegSrc;
        o.ret    = bus.Retire;
        o.ill    = bus.Illegal;
        return o;
    endfunction

    // Drives the first ncyc cycles of the built trace; entry and exit
    // are 1 time unit after a rising edge.
    task automatic run_instr(logic [1:0] op, logic [5:0] f, int ncyc);
        obs_q.delete();
        bus.Op    = op;
        bus.Funct = f;
        for (int k = 0; k < ncyc && k < exp_q.size(); k++) begin
            bus.MemReady = mr_q[k];
            @(negedge clk);
            obs_q.push_back(sample());
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        reset_n      = 1'b0;
        bus.Op       = 2'b00;
        bus.Funct    = 6'h00;
        bus.MemReady = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (bus.State !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_state got %0d expected 0", bus.State);
        end
        n_checks++;
        if ({bus.IRWrite, bus.NextPC, bus.RegW, bus.MemW, bus.Branch,
             bus.Retire, bus.Illegal} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_strobes got %b expected 0000000",
                     {bus.IRWrite, bus.NextPC, bus.RegW, bus.MemW,
                      bus.Branch, bus.Retire, bus.Illegal});
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic test_dp_reg();
        int nregw, nret;
        build(2'b00, 6'b000000, 0, 0);
        run_instr(2'b00, 6'b000000, exp_q.size());
        nregw = 0;
        nret  = 0;
        foreach (exp_q[k]) begin
            n_checks++;
            if (obs_q[k] !== exp_q[k]) begin
                n_fail++;
                $display("FAIL dp_reg cycle %0d got %h expected %h",
                         k, obs_q[k], exp_q[k]);
            end
            nregw += int'(obs_q[k].regw);
            nret  += int'(obs_q[k].ret);
        end
        n_checks++;
        if (nregw != 1 || nret != 1) begin
            n_fail++;
            $display("FAIL dp_reg_counts got regw=%0d ret=%0d expected 1 1",
                     nregw, nret);
        end
    endtask

    task automatic test_load_stall();
        build(2'b01, 6'b000001, 0, 2);
        run_instr(2'b01, 6'b000001, exp_q.size());
        foreach (exp_q[k]) begin
            n_checks++;
            if (obs_q[k] !== exp_q[k]) begin
                n_fail++;
                $display("FAIL load_stall cycle %0d got %h expected %h",
                         k, obs_q[k], exp_q[k]);
            end
        end
    endtask

    task automatic test_store();
        build(2'b01, 6'b100000, 0, 0);
        run_instr(2'b01, 6'b100000, exp_q.size());
        foreach (exp_q[k]) begin
            n_checks++;
            if (obs_q[k] !== exp_q[k]) begin
                n_fail++;
                $display("FAIL store cycle %0d got %h expected %h",
                         k, obs_q[k], exp_q[k]);
            end
        end
    endtask

    task automatic test_branch();
        build(2'b10, 6'b010101, 1, 0);
        run_instr(2'b10, 6'b010101, exp_q.size());
        foreach (exp_q[k]) begin
            n_checks++;
            if (obs_q[k] !== exp_q[k]) begin
                n_fail++;
                $display("FAIL branch cycle %0d got %h expected %h",
                         k, obs_q[k], exp_q[k]);
            end
        end
    endtask

    task automatic test_illegal();
        int nill, nwr;
        build(2'b11, 6'b111111, 0, 0);
        run_instr(2'b11, 6'b111111, exp_q.size());
        nill = 0;
        nwr  = 0;
        foreach (exp_q[k]) begin
            n_checks++;
            if (obs_q[k] !== exp_q[k]) begin
                n_fail++;
                $display("FAIL illegal cycle %0d got %h expected %h",
                         k, obs_q[k], exp_q[k]);
            end
            nill += int'(obs_q[k].ill);
            nwr  += int'(obs_q[k].regw) + int'(obs_q[k].memw);
        end
        n_checks++;
        if (nill != 1 || nwr != 0) begin
            n_fail++;
            $display("FAIL illegal_counts got ill=%0d wr=%0d expected 1 0",
                     nill, nwr);
        end
    endtask

    task automatic test_random_stream();
        logic [1:0] op;
        logic [5:0] f;
        int nirw, nret, nill;
        for (int n = 0; n < 60; n++) begin
            op = 2'($urandom_range(0, 3));
            f  = 6'($urandom);
            build(op, f, $urandom_range(0, 3), $urandom_range(0, 3));
            run_instr(op, f, exp_q.size());
            nirw = 0;
            nret = 0;
            nill = 0;
            foreach (exp_q[k]) begin
                n_checks++;
                if (obs_q[k] !== exp_q[k]) begin
                    n_fail++;
                    $display("FAIL random n=%0d cycle %0d got %h expected %h",
                             n, k, obs_q[k], exp_q[k]);
                end
                nirw += int'(obs_q[k].irw);
                nret += int'(obs_q[k].ret);
                nill += int'(obs_q[k].ill);
            end
            n_checks++;
            if (nirw != 1 || nret != int'(op != 2'b11) ||
                nill != int'(op == 2'b11)) begin
                n_fail++;
                $display("FAIL random_counts n=%0d got irw=%0d ret=%0d ill=%0d",
                         n, nirw, nret, nill);
            end
        end
        @(negedge clk);
        n_checks++;
        if (bus.State !== 4'd0) begin
            n_fail++;
            $display("FAIL random_end_state got %0d expected 0", bus.State);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_store();
        build(2'b01, 6'b000000, 3, 4);
        run_instr(2'b01, 6'b000000, 8);
        foreach (obs_q[k]) begin
            n_checks++;
            if (obs_q[k] !== exp_q[k]) begin
                n_fail++;
                $display("FAIL mid_store cycle %0d got %h expected %h",
                         k, obs_q[k], exp_q[k]);
            end
        end
        bus.MemReady = 1'b0;
        #1;
        n_checks++;
        if (bus.State !== 4'd5 || bus.MemW !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_store_pre got st=%0d memw=%b expected 5 1",
                     bus.State, bus.MemW);
        end
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (bus.State !== 4'd0 || bus.MemW !== 1'b0 || bus.Retire !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset got st=%0d memw=%b ret=%b expected 0 0 0",
                     bus.State, bus.MemW, bus.Retire);
        end
        bus.MemReady = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.IRWrite !== 1'b0 || bus.NextPC !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_fetch got irw=%b npc=%b expected 0 0",
                     bus.IRWrite, bus.NextPC);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (bus.State !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_hold got %0d expected 0", bus.State);
        end
        reset_n = 1'b1;
        build(2'b00, 6'b100000, 1, 0);
        run_instr(2'b00, 6'b100000, exp_q.size());
        foreach (exp_q[k]) begin
            n_checks++;
            if (obs_q[k] !== exp_q[k]) begin
                n_fail++;
                $display("FAIL post_reset cycle %0d got %h expected %h",
                         k, obs_q[k], exp_q[k]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_dp_reg();
        test_load_stall();
        test_store();
        test_branch();
        test_illegal();
        test_random_stream();
        test_reset_mid_store();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule
